// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared command encodings, mode-register layout and FSM states
// for the SDRAM responder.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_BST   = 4'b0110;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam int MODE_BL_LSB  = 0;
    localparam int MODE_BL_MSB  = 2;
    localparam int MODE_SEQ_BIT = 3;
    localparam int MODE_CL_LSB  = 4;
    localparam int MODE_CL_MSB  = 6;
    localparam int MODE_WBL_BIT = 9;

    localparam logic [14:0] MODE_RESET = 15'b000000000100010;

    typedef enum logic [2:0] {C_NOP, C_ACT, C_READ, C_WRITE, C_BST, C_MRS} cmd_e;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_e;

    // Only the mode fields the responder acts on; BL is kept as log2 (0..3).
    typedef struct packed {
        logic       wsingle;
        logic [2:0] cl;
        logic       intlv;
        logic [1:0] blog;
    } mode_t;

    localparam mode_t MODE_RESET_FIELDS = '{
        wsingle: MODE_RESET[MODE_WBL_BIT],
        cl:      MODE_RESET[MODE_CL_MSB:MODE_CL_LSB],
        intlv:   MODE_RESET[MODE_SEQ_BIT],
        blog:    MODE_RESET[MODE_BL_LSB+1:MODE_BL_LSB]
    };

    function automatic cmd_e decode_cmd(input logic [3:0] pins);
        cmd_e c;
        c = C_NOP;
        if (!pins[3]) begin
            case (pins)
                CMD_ACT:   c = C_ACT;
                CMD_READ:  c = C_READ;
                CMD_WRITE: c = C_WRITE;
                CMD_BST:   c = C_BST;
                CMD_MRS:   c = C_MRS;
                default:   c = C_NOP;
            endcase
        end
        decode_cmd = c;
    endfunction

endpackage

// File: rtl/sdram_bank_array.sv
// rtl/sdram_bank_array.sv - word storage with a byte-enabled write port and a
// registered (1-cycle) read port; contents are never reset.
module sdram_bank_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [1:0]    wbe_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [2**AW];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i && wbe_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
        if (we_i && wbe_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
        if (re_i)             rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - behavioural SDRAM device: command decode, bank/row
// tracking, burst FSM and a CL-deep read pipeline behind the storage array.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CKE,
    input  logic        CS_N,
    input  logic        RAS_N,
    input  logic        CAS_N,
    input  logic        WE_N,
    input  logic [1:0]  BA,
    input  logic [12:0] ADDR,
    input  logic [1:0]  DMASK,
    input  logic [15:0] DQ_in,
    output logic [15:0] DQ_out,
    output logic        DQ_oe,
    output logic        err
);

    localparam int AW = 2 + ROW_BITS + COL_BITS;

    cmd_e                cmd;
    state_e              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [3:0]          active_q, active_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] brow_q, brow_d;
    logic [1:0]          bank_q, bank_d;
    logic [COL_BITS-1:0] start_q, start_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          blog_q, blog_d;
    logic                intlv_q, intlv_d;
    logic                ap_q, ap_d;
    logic                err_q, err_d;
    logic                rd_v0_q, rd_v0_d, rd_v1_q;
    logic [15:0]         rd_d1_q, dq_out_q;
    logic                dq_oe_q;

    logic                rw_cmd, rw_ok, act_ok, burst_end;
    logic                beat, beat_rd;
    logic [AW-1:0]       beat_addr;
    logic [15:0]         rdata;
    logic                sel_v;
    logic [15:0]         sel_d;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{ADDR[12:11], ADDR[8:7]};

    function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] start,
                                                      input logic [3:0] i,
                                                      input logic [1:0] blog,
                                                      input logic intlv);
        logic [COL_BITS-1:0] mask, idx, low;
        mask = COL_BITS'((1 << blog) - 1);
        idx  = COL_BITS'(i);
        low  = intlv ? (start ^ idx) : (start + idx);
        burst_col = (start & ~mask) | (low & mask);
    endfunction

    assign cmd    = CKE ? decode_cmd({CS_N, RAS_N, CAS_N, WE_N}) : C_NOP;
    assign rw_cmd = (cmd == C_READ) || (cmd == C_WRITE);
    assign rw_ok  = rw_cmd && active_q[BA];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        active_d  = active_q;
        brow_d    = brow_q;
        bank_d    = bank_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        blog_d    = blog_q;
        intlv_d   = intlv_q;
        ap_d      = ap_q;
        err_d     = 1'b0;
        act_ok    = 1'b0;
        burst_end = 1'b0;
        beat      = 1'b0;
        beat_rd   = (state_q == RD_BURST);
        beat_addr = {bank_q, brow_q, burst_col(start_q, cnt_q, blog_q, intlv_q)};

        // A running burst ends on its last beat, on BST, or when a new access takes over.
        if (state_q != IDLE) begin
            if (cmd == C_BST || rw_ok) begin
                burst_end = 1'b1;
            end else begin
                beat  = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == ((4'd1 << blog_q) - 4'd1)) burst_end = 1'b1;
            end
            if (burst_end) begin
                state_d = IDLE;
                if (ap_q) active_d[bank_q] = 1'b0;
            end
        end

        if (rw_ok) begin
            beat      = 1'b1;
            beat_rd   = (cmd == C_READ);
            beat_addr = {BA, row_q[BA], ADDR[COL_BITS-1:0]};
            bank_d    = BA;
            brow_d    = row_q[BA];
            start_d   = ADDR[COL_BITS-1:0];
            cnt_d     = 4'd1;
            intlv_d   = mode_q.intlv;
            ap_d      = ADDR[10];
            blog_d    = (cmd == C_WRITE && mode_q.wsingle) ? 2'd0 : mode_q.blog;
            if (blog_d == 2'd0) begin
                state_d = IDLE;
                if (ADDR[10]) active_d[BA] = 1'b0;
            end else begin
                state_d = (cmd == C_READ) ? RD_BURST : WR_BURST;
            end
        end else if (rw_cmd) begin
            err_d = 1'b1;
        end

        if (cmd == C_ACT) begin
            if (active_q[BA]) begin
                err_d = 1'b1;
            end else begin
                active_d[BA] = 1'b1;
                act_ok       = 1'b1;
            end
        end

        if (cmd == C_MRS) begin
            if ((ADDR[MODE_CL_MSB:MODE_CL_LSB] == 3'd2 || ADDR[MODE_CL_MSB:MODE_CL_LSB] == 3'd3)
                && ADDR[MODE_BL_MSB:MODE_BL_LSB] <= 3'd3) begin
                mode_d.wsingle = ADDR[MODE_WBL_BIT];
                mode_d.cl      = ADDR[MODE_CL_MSB:MODE_CL_LSB];
                mode_d.intlv   = ADDR[MODE_SEQ_BIT];
                mode_d.blog    = ADDR[MODE_BL_LSB+1:MODE_BL_LSB];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign rd_v0_d = beat && beat_rd;

    sdram_bank_array #(.AW(AW)) u_array (
        .clk     (clk),
        .we_i    (beat && !beat_rd),
        .waddr_i (beat_addr),
        .wdata_i (DQ_in),
        .wbe_i   (~DMASK),
        .re_i    (rd_v0_d),
        .raddr_i (beat_addr),
        .rdata_o (rdata)
    );

    // The array register is the first latency stage; CL=3 adds one more before DQ_out.
    assign sel_v = (mode_q.cl == 3'd3) ? rd_v1_q : rd_v0_q;
    assign sel_d = (mode_q.cl == 3'd3) ? rd_d1_q : rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE_RESET_FIELDS;
            active_q <= '0;
            for (int b = 0; b < 4; b++) row_q[b] <= '0;
            brow_q   <= '0;
            bank_q   <= '0;
            start_q  <= '0;
            cnt_q    <= '0;
            blog_q   <= '0;
            intlv_q  <= 1'b0;
            ap_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_v0_q  <= 1'b0;
            rd_v1_q  <= 1'b0;
            rd_d1_q  <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            if (CKE) begin
                state_q  <= state_d;
                mode_q   <= mode_d;
                active_q <= active_d;
                if (act_ok) row_q[BA] <= ADDR[ROW_BITS-1:0];
                brow_q   <= brow_d;
                bank_q   <= bank_d;
                start_q  <= start_d;
                cnt_q    <= cnt_d;
                blog_q   <= blog_d;
                intlv_q  <= intlv_d;
                ap_q     <= ap_d;
                rd_v0_q  <= rd_v0_d;
                rd_v1_q  <= rd_v0_q;
                rd_d1_q  <= rdata;
                dq_oe_q  <= sel_v;
                if (sel_v) dq_out_q <= sel_d;
            end
        end
    end

    assign DQ_out = dq_out_q;
    assign DQ_oe  = dq_oe_q;
    assign err    = err_q;

endmodule
